lzd_norm_pipe: RTL and testbench

Parametrised, pipelined leading-digit detector and normaliser for the fpadd datapath. Accepts a WIDTH-bit operand under valid/ready handshake, counts leading zeros (or leading ones, per-transaction mode) and returns the count, an all-same flag and the operand left-shifted by the count. Sits between the significand adder and the exponent-adjust/rounding stage. Sustains one transaction per cycle with full backpressure.

---
 rtl/lzd_norm_pipe.sv | 122 ++++++++++++
 tb/tb_lzd_norm_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lzd_norm_pipe.sv
// Two-stage leading-zero/one detector and normaliser with valid/ready handshake.
// Optional: define LZNORM_TAG_EN to carry in_tag alongside each result.
module lzd_norm_pipe #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned TAG_W = 4,
    localparam int unsigned CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_cnt,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LW = $clog2(WIDTH);

    logic             s1_valid_q, s2_valid_q;
    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] s1_data_q, s2_norm_q;
    logic [CW-1:0]    s1_cnt_q, s2_cnt_q;
    logic             s2_zero_q;

    logic [WIDTH-1:0] scan;
    logic             top_v;
    logic [LW-1:0]    top_c;
    logic [CW-1:0]    cnt;

    // Leading-ones mode counts leading zeros of the complement.
    assign scan = in_mode ? ~in_data : in_data;

    // Level l holds WIDTH>>l nodes, each with an l-bit count of its 2^l-bit span.
    for (genvar l = 1; l <= LW; l++) begin : g_lvl
        localparam int unsigned N = WIDTH >> l;
        logic [N-1:0]        v;
        logic [N-1:0][l-1:0] c;
        for (genvar i = 0; i < N; i++) begin : g_node
            if (l == 1) begin : g_leaf
                assign v[i] = scan[2*i+1] | scan[2*i];
                assign c[i] = ~scan[2*i+1];
            end else begin : g_merge
                assign v[i] = g_lvl[l-1].v[2*i+1] | g_lvl[l-1].v[2*i];
                assign c[i] = g_lvl[l-1].v[2*i+1] ? {1'b0, g_lvl[l-1].c[2*i+1]}
                                                  : {1'b1, g_lvl[l-1].c[2*i]};
            end
        end
    end

    assign top_v = g_lvl[LW].v[0];
    assign top_c = g_lvl[LW].c[0];
    assign cnt   = top_v ? {1'b0, top_c} : CW'(WIDTH);

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (s2_adv) s2_valid_q <= s1_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q <= '0;
            s1_cnt_q  <= '0;
        end else if (in_valid && s1_adv) begin
            s1_data_q <= in_data;
            s1_cnt_q  <= cnt;
        end
    end

    // A count of WIDTH (MSB set) means no terminating digit; the shift then yields zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_cnt_q  <= '0;
            s2_zero_q <= 1'b0;
            s2_norm_q <= '0;
        end else if (s1_valid_q && s2_adv) begin
            s2_cnt_q  <= s1_cnt_q;
            s2_zero_q <= s1_cnt_q[CW-1];
            s2_norm_q <= s1_data_q << s1_cnt_q;
        end
    end

`ifdef LZNORM_TAG_EN
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_tag_q <= '0;
            s2_tag_q <= '0;
        end else begin
            if (in_valid && s1_adv)   s1_tag_q <= in_tag;
            if (s1_valid_q && s2_adv) s2_tag_q <= s1_tag_q;
        end
    end

    assign out_tag = s2_tag_q;
`else
    logic unused_tag;
    assign unused_tag = ^in_tag;
    assign out_tag    = '0;
`endif

    assign out_valid = s2_valid_q;
    assign out_cnt   = s2_cnt_q;
    assign out_zero  = s2_zero_q;
    assign out_norm  = s2_norm_q;

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Self-checking bench for lzd_norm_pipe: directed vectors, random backpressure, mid-stream reset.
module tb_lzd_norm_pipe;

    localparam int W  = 64;
    localparam int CW = 7;

    logic          clk, rst_n;
    logic          in_valid, in_ready, in_mode;
    logic [W-1:0]  in_data;
    logic [3:0]    in_tag, out_tag;
    logic          out_valid, out_ready, out_zero;
    logic [CW-1:0] out_cnt;
    logic [W-1:0]  out_norm;

    typedef struct {
        logic [W-1:0] d;
        logic         m;
        logic [3:0]   t;
        int           c;
    } txn_t;

    txn_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    lzd_norm_pipe #(.WIDTH(W), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt),
        .out_zero  (out_zero),
        .out_norm  (out_norm),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of leading digits equal to m, scanning down from the MSB.
    function automatic int ref_cnt(input logic m, input logic [W-1:0] d);
        int n = 0;
        while (n < W && d[W-1-n] == m) n++;
        return n;
    endfunction

    function automatic logic [W-1:0] ref_norm(input logic m, input logic [W-1:0] d);
        int n = ref_cnt(m, d);
        return (n >= W) ? '0 : (d << n);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called once per cycle, a few ns before the rising edge, with inputs settled.
    task automatic sample();
        txn_t        e;
        bit          exp_ov;
        int          n;
        logic [3:0]  etag;
        chk("in_ready", {63'd0, in_ready}, {63'd0, !(q.size() == 2 && !out_ready)});
        exp_ov = (q.size() > 0) && (q[0].c <= cyc - 2);
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
        if (exp_ov && out_valid) begin
            e = q[0];
            n = ref_cnt(e.m, e.d);
`ifdef LZNORM_TAG_EN
            etag = e.t;
`else
            etag = 4'd0;
`endif
            chk("out_cnt", {57'd0, out_cnt}, W'(n));
            chk("out_zero", {63'd0, out_zero}, {63'd0, n == W});
            chk("out_norm", out_norm, ref_norm(e.m, e.d));
            chk("out_tag", {60'd0, out_tag}, {60'd0, etag});
            if (out_ready) void'(q.pop_front());
        end
        if (in_valid && in_ready) q.push_back('{in_data, in_mode, in_tag, cyc});
        cyc++;
    endtask

    // Present one operand and hold it until accepted.
    task automatic send(input logic m, input logic [W-1:0] d, input logic [3:0] t,
                        input bit rnd_rdy);
        bit done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_mode   = m;
            in_data   = d;
            in_tag    = t;
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            done = in_ready;
            sample();
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #2;
            sample();
        end
        chk("drain_left", W'(q.size()), 64'd0);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic [3:0] t,
                        input logic rdy);
        @(negedge clk);
        in_valid  = v;
        in_mode   = 1'b0;
        in_data   = d;
        in_tag    = t;
        out_ready = rdy;
        #2;
        sample();
    endtask

    logic         vm [9] = '{0, 0, 0, 1, 1, 1, 0, 1, 1};
    logic [W-1:0] vd [9] = '{64'h0000_0000_0001_0000, 64'h0, 64'h8000_0000_0000_0000,
                             64'hFFF0_0000_0000_1234, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                             64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    int           vc [9] = '{47, 64, 0, 12, 64, 0, 63, 0, 63};
    logic [W-1:0] vn [9] = '{64'h8000_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000,
                             64'h0000_0000_0123_4000, 64'h0, 64'h0,
                             64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0};

    initial begin
        logic [W-1:0] d;
        logic         m;
        in_valid = 0; in_mode = 0; in_data = '0; in_tag = '0; out_ready = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_cnt", {57'd0, out_cnt}, 64'd0);
        chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
        chk("rst_out_norm", out_norm, 64'd0);
        chk("rst_out_tag", {60'd0, out_tag}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        sample();

        // Directed vectors: pin the model to hand values, then run them through the DUT.
        for (int i = 0; i < 9; i++) begin
            chk("model_cnt", W'(ref_cnt(vm[i], vd[i])), W'(vc[i]));
            chk("model_norm", ref_norm(vm[i], vd[i]), vn[i]);
            send(vm[i], vd[i], 4'(i), 1'b0);
        end
        drain();

        // Random operands with random backpressure, tags cycling 0..15.
        for (int i = 0; i < 100; i++) begin
            m = 1'($urandom_range(0, 1));
            d = {$urandom(), $urandom()} >> $urandom_range(0, W);
            if (m) d = ~d;
            send(m, d, 4'(i), 1'b1);
        end
        drain();

        // Full-rate stream: one result per cycle.
        for (int i = 0; i < 100; i++) begin
            m = 1'($urandom_range(0, 1));
            d = {$urandom(), $urandom()} >> $urandom_range(0, W);
            if (m) d = ~d;
            send(m, d, 4'(i + 3), 1'b0);
        end
        drain();

        // Fill both stages, then reset mid-stream.
        step(1'b1, 64'h1, 4'h1, 1'b0);
        step(1'b1, 64'h2, 4'h2, 1'b0);
        step(1'b1, 64'h3, 4'h3, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_cnt", {57'd0, out_cnt}, 64'd0);
        chk("midrst_out_zero", {63'd0, out_zero}, 64'd0);
        chk("midrst_out_norm", out_norm, 64'd0);
        chk("midrst_out_tag", {60'd0, out_tag}, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        sample();
        send(1'b0, 64'h0000_0100_0000_0000, 4'h9, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
